// File: rtl/psum_accumulator_if.sv
// Psum input and result output handshake bundle for psum_accumulator.
// slave is the accumulator side, master is the producer/consumer side.
interface psum_accumulator_if #(
  parameter int PSUM_W = 32
);
  logic              psum_valid;
  logic [PSUM_W-1:0] psum;
  logic              psum_ready;
  logic              out_valid;
  logic              out_ready;
  logic [PSUM_W-1:0] out_data;
  logic              out_sat;

  modport slave (
    input  psum_valid,
    input  psum,
    output psum_ready,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_sat
  );

  modport master (
    output psum_valid,
    output psum,
    input  psum_ready,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_sat
  );
endinterface

// File: rtl/psum_accumulator.sv
// Sums acc_len consecutive signed psums and emits one saturated
// result through a valid/ready handshake.
module psum_accumulator #(
  parameter int PSUM_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               start,
  input  logic [CNT_W-1:0]   acc_len,
  output logic               busy,
  output logic               done,
  psum_accumulator_if.slave  bus
);

  localparam int ACC_W = PSUM_W + CNT_W;

  localparam logic signed [ACC_W-1:0] SMAX =
    {{(ACC_W-PSUM_W+1){1'b0}}, {(PSUM_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN =
    {{(ACC_W-PSUM_W+1){1'b1}}, {(PSUM_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic signed [ACC_W-1:0] acc;
  logic        [CNT_W-1:0] cnt;
  logic        [CNT_W-1:0] len;
  logic        [PSUM_W-1:0] data_q;
  logic                     sat_q;
  logic                     done_q;

  logic signed [ACC_W-1:0] sum;
  logic        [CNT_W-1:0] cnt_nxt;
  logic                     last;
  logic                     fire_in;
  logic                     fire_out;
  logic        [PSUM_W-1:0] sat_data;
  logic                     sat_flag;

  assign bus.psum_ready = (state == ACCUM);
  assign bus.out_valid  = (state == OUT);
  assign bus.out_data   = data_q;
  assign bus.out_sat    = sat_q;
  assign busy           = (state != IDLE);
  assign done           = done_q;

  assign fire_in  = bus.psum_valid & bus.psum_ready;
  assign fire_out = bus.out_valid & bus.out_ready;

  assign sum     = acc + ACC_W'($signed(bus.psum));
  assign cnt_nxt = cnt + 1'b1;
  assign last    = (cnt_nxt == len);

  // Clamp the wide running sum into the output width.
  always_comb begin
    sat_data = sum[PSUM_W-1:0];
    sat_flag = 1'b0;
    if (sum > SMAX) begin
      sat_data = SMAX[PSUM_W-1:0];
      sat_flag = 1'b1;
    end else if (sum < SMIN) begin
      sat_data = SMIN[PSUM_W-1:0];
      sat_flag = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (acc_len == '0) ? OUT : ACCUM;
        end
      end
      ACCUM: begin
        if (fire_in && last) begin
          state_nxt = OUT;
        end
      end
      OUT: begin
        if (fire_out) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      acc    <= '0;
      cnt    <= '0;
      len    <= '0;
      data_q <= '0;
      sat_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= fire_out;
      unique case (state)
        IDLE: begin
          if (start) begin
            len <= acc_len;
            acc <= '0;
            cnt <= '0;
            if (acc_len == '0) begin
              data_q <= '0;
              sat_q  <= 1'b0;
            end
          end
        end
        ACCUM: begin
          if (fire_in) begin
            acc <= sum;
            cnt <= cnt_nxt;
            if (last) begin
              data_q <= sat_data;
              sat_q  <= sat_flag;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator with hand-computed results.
// Inputs change 1ns after posedge; outputs are checked there too.
module tb_psum_accumulator;

  logic        clk;
  logic        RST;
  logic        start;
  logic [15:0] acc_len;
  logic        busy;
  logic        done;

  int n_vec;
  int n_bad;

  psum_accumulator_if #(.PSUM_W(32)) bus ();

  psum_accumulator #(
    .PSUM_W (32),
    .CNT_W  (16)
  ) dut (
    .clk     (clk),
    .RST     (RST),
    .start   (start),
    .acc_len (acc_len),
    .busy    (busy),
    .done    (done),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic v, input logic [31:0] d);
    bus.psum_valid = v;
    bus.psum       = d;
    chk("psum_ready_accum", 32'(bus.psum_ready), 32'd1);
    tick();
  endtask

  task automatic go(input logic [15:0] n);
    start   = 1'b1;
    acc_len = n;
    tick();
    start   = 1'b0;
  endtask

  task automatic drain(input string tag,
                       input logic [31:0] d,
                       input logic s);
    bus.psum_valid = 1'b0;
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_data"}, bus.out_data, d);
    chk({tag, "_sat"}, 32'(bus.out_sat), 32'(s));
    chk({tag, "_pready"}, 32'(bus.psum_ready), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_vlow"}, 32'(bus.out_valid), 32'd0);
    tick();
    chk({tag, "_done_end"}, 32'(done), 32'd0);
  endtask

  initial begin
    n_vec          = 0;
    n_bad          = 0;
    RST            = 1'b1;
    start          = 1'b0;
    acc_len        = '0;
    bus.psum_valid = 1'b0;
    bus.psum       = '0;
    bus.out_ready  = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_pready", 32'(bus.psum_ready), 32'd0);
    chk("rst_data", bus.out_data, 32'd0);
    chk("rst_sat", 32'(bus.out_sat), 32'd0);
    RST = 1'b0;
    tick();

    // 1: 5 - 3 + 10 + 7 = 19
    go(16'd4);
    chk("t1_busy", 32'(busy), 32'd1);
    beat(1'b1, 32'd5);
    beat(1'b1, -32'sd3);
    beat(1'b1, 32'd10);
    chk("t1_not_yet", 32'(bus.out_valid), 32'd0);
    beat(1'b1, 32'd7);
    drain("t1", 32'd19, 1'b0);

    // 2: only valid beats count: 100 + 200 - 50 = 250
    go(16'd3);
    beat(1'b1, 32'd100);
    beat(1'b0, 32'd999);
    beat(1'b1, 32'd200);
    beat(1'b0, 32'd999);
    chk("t2_not_yet", 32'(bus.out_valid), 32'd0);
    beat(1'b1, -32'sd50);
    drain("t2", 32'd250, 1'b0);

    // 3: positive and negative clamp
    go(16'd2);
    beat(1'b1, 32'h7FFF_FFFF);
    beat(1'b1, 32'h7FFF_FFFF);
    drain("t3p", 32'h7FFF_FFFF, 1'b1);
    go(16'd2);
    beat(1'b1, 32'h8000_0000);
    beat(1'b1, 32'h8000_0000);
    drain("t3n", 32'h8000_0000, 1'b1);

    // 4: result held under back-pressure, start ignored in OUT
    go(16'd1);
    beat(1'b1, 32'd42);
    bus.psum_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t4_hold_data", bus.out_data, 32'd42);
      chk("t4_hold_pready", 32'(bus.psum_ready), 32'd0);
      start   = (i == 2);
      acc_len = 16'd7;
      tick();
    end
    start = 1'b0;
    drain("t4", 32'd42, 1'b0);

    // 5: zero-length job emits 0 next cycle, consumes nothing
    bus.psum_valid = 1'b1;
    bus.psum       = 32'd77;
    go(16'd0);
    drain("t5", 32'd0, 1'b0);

    // 6: reset mid-job (with start held) then a fresh job
    go(16'd8);
    beat(1'b1, 32'd11);
    beat(1'b1, 32'd22);
    beat(1'b1, 32'd33);
    bus.psum_valid = 1'b0;
    RST     = 1'b1;
    start   = 1'b1;
    acc_len = 16'd5;
    tick();
    RST   = 1'b0;
    start = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_pready", 32'(bus.psum_ready), 32'd0);
    chk("t6_data", bus.out_data, 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    tick();
    chk("t6_still_idle", 32'(busy), 32'd0);
    go(16'd2);
    beat(1'b1, 32'd1);
    beat(1'b1, 32'd2);
    drain("t6", 32'd3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
